// File: rtl/pipe_defs.sv
// Shared pipeline definitions: instruction encodings, pipeline-register
// widths and the fetch/decode FSM state encoding. fd_pipe, DX_pipe and
// later stages all import this package.
package pipe_defs;

  // Width of the instruction and PC fields carried by every pipeline register.
  localparam int PIPE_W = 16;

  // Bubble encoding (opcode 00001). 16'h0000 is HALT, so it can never be
  // used as a bubble.
  localparam logic [PIPE_W-1:0] PIPE_NOP  = 16'h0800;
  localparam logic [PIPE_W-1:0] PIPE_HALT = 16'h0000;

  // Fetch/decode register FSM state encoding.
  typedef enum logic {
    FD_RUN  = 1'b0,
    FD_DROP = 1'b1
  } fd_state_e;

  // Contents carried from fetch into decode.
  typedef struct packed {
    logic [PIPE_W-1:0] instr;
    logic [PIPE_W-1:0] pc2;
    logic              err;
  } fd_word_t;

  localparam int FD_WORD_W = $bits(fd_word_t);

endpackage

// File: rtl/fd_pipe_if.sv
// Fetch -> decode handshake bundle. The master modport belongs to the
// fetch stage / hazard unit side, the slave modport to fd_pipe.
interface fd_pipe_if
  import pipe_defs::*;
#(
  parameter int DATA_W = PIPE_W
) ();

  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [DATA_W-1:0] if_pc2;
  logic              if_err;
  logic              if_busy;
  logic              stall;
  logic              flush;
  logic              fd_ready;
  logic [DATA_W-1:0] FD_instr;
  logic [DATA_W-1:0] FD_pc2;
  logic              FD_valid;
  logic              FD_err;

  modport master (
    output if_valid, if_instr, if_pc2, if_err, if_busy, stall, flush,
    input  fd_ready, FD_instr, FD_pc2, FD_valid, FD_err
  );

  modport slave (
    input  if_valid, if_instr, if_pc2, if_err, if_busy, stall, flush,
    output fd_ready, FD_instr, FD_pc2, FD_valid, FD_err
  );

endinterface

// File: rtl/fd_skid_buf.sv
// One-entry holding register for a fetch accepted while decode is stalled.
// Keeps instr / pc2 / err together with a full flag. clear_i wins over
// pop_i, which wins over push_i.
module fd_skid_buf
  import pipe_defs::*;
#(
  parameter int DATA_W = PIPE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [DATA_W-1:0] pc2_i,
  input  logic              err_i,
  output logic              full_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] pc2_o,
  output logic              err_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] instr_q, pc2_q;
  logic              err_q;
  logic              load;

  assign load = push_i & ~clear_i & ~pop_i;

  // Occupancy: flush or drain empties the entry, a push fills it.
  always_comb begin
    full_d = full_q;
    if (clear_i || pop_i) begin
      full_d = 1'b0;
    end else if (push_i) begin
      full_d = 1'b1;
    end
  end

  // Full flag and held fetch word, written together on a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc2_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      full_q <= full_d;
      if (load) begin
        instr_q <= instr_i;
        pc2_q   <= pc2_i;
        err_q   <= err_i;
      end
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc2_o   = pc2_q;
  assign err_o   = err_q;

endmodule

// File: rtl/fd_pipe.sv
// Fetch -> decode pipeline register of the 5-stage WISC CPU.
// Holds its contents on a hazard stall, turns into a bubble on a taken
// branch/jump flush, and drops the stale fetch still in flight when a
// flush lands while instruction memory is busy.
// Build option: define FD_SKID_EN to add a 1-entry skid buffer so a fetch
// arriving during a stall is captured instead of back-pressured.
module fd_pipe
  import pipe_defs::*;
#(
  parameter int                DATA_W    = PIPE_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = PIPE_NOP
) (
  input  logic      clk,
  input  logic      rst,
  fd_pipe_if.slave  bus
);

  fd_state_e         state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pc2_q, pc2_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              in_run;
  logic              fd_ready;
  logic              accept;
  logic              skid_full;
  logic [DATA_W-1:0] skid_instr, skid_pc2;
  logic              skid_err;

  assign in_run = (state_q == FD_RUN);

`ifdef FD_SKID_EN
  logic skid_push, skid_pop;

  // A fetch offered while decode is stalled parks in the skid; it drains
  // into FD on the first cycle that is neither stalled nor flushed.
  assign skid_push = in_run & bus.stall & bus.if_valid & ~skid_full & ~bus.flush;
  assign skid_pop  = skid_full & ~bus.stall & ~bus.flush;
  assign fd_ready  = ~in_run | ~skid_full;

  fd_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .clear_i (bus.flush),
    .instr_i (bus.if_instr),
    .pc2_i   (bus.if_pc2),
    .err_i   (bus.if_err),
    .full_o  (skid_full),
    .instr_o (skid_instr),
    .pc2_o   (skid_pc2),
    .err_o   (skid_err)
  );
`else
  // No storage: fetch is simply held off while decode is stalled.
  assign skid_full  = 1'b0;
  assign skid_instr = '0;
  assign skid_pc2   = '0;
  assign skid_err   = 1'b0;
  assign fd_ready   = ~in_run | ~bus.stall;
`endif

  assign accept = bus.if_valid & fd_ready;

  // Next state: enter DROP when a flush leaves a fetch outstanding in imem;
  // leave on the first returning fetch unless another flush arrives.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FD_RUN: begin
        if (bus.flush && bus.if_busy && !bus.if_valid) begin
          state_d = FD_DROP;
        end
      end
      FD_DROP: begin
        if (!bus.flush && bus.if_valid) begin
          state_d = FD_RUN;
        end
      end
      default: state_d = FD_RUN;
    endcase
  end

  // FD contents: flush > stall > load (skid first, then fetch) > bubble.
  always_comb begin
    instr_d = instr_q;
    pc2_d   = pc2_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (bus.flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (bus.stall) begin
      // hold everything for the hazard
    end else if (in_run && skid_full) begin
      instr_d = skid_instr;
      pc2_d   = skid_pc2;
      valid_d = 1'b1;
      err_d   = skid_err;
    end else if (in_run && accept) begin
      instr_d = bus.if_instr;
      pc2_d   = bus.if_pc2;
      valid_d = 1'b1;
      err_d   = bus.if_err;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FD_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FD pipeline register; reset presents a bubble immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc2_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc2_q   <= pc2_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.fd_ready = fd_ready;
  assign bus.FD_instr = instr_q;
  assign bus.FD_pc2   = pc2_q;
  assign bus.FD_valid = valid_q;
  assign bus.FD_err   = err_q;

endmodule

// File: tb/tb_fd_pipe.sv
// Self-checking bench for fd_pipe. Each step drives one cycle of fetch /
// hazard inputs, pushes the expected FD outputs to a scoreboard queue and
// records what the DUT shows 1 ns after the edge; each test then drains
// the scoreboard. Expected ready during a stall depends on FD_SKID_EN.
module tb_fd_pipe;
  import pipe_defs::*;

`ifdef FD_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        valid;
    logic        err;
    logic        ready;
  } obs_t;

  logic clk = 1'b0;
  logic rst;

  obs_t  exp_q[$];
  obs_t  obs_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  fd_pipe_if #(.DATA_W(16)) bus ();

  fd_pipe #(.DATA_W(16), .NOP_INSTR(16'h0800)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ctl = {if_valid, if_err, if_busy, stall, flush}; xf = {valid, err, ready}
  task automatic step(input string tag, input logic [4:0] ctl,
                      input logic [15:0] ins, input logic [15:0] pc,
                      input logic [15:0] xi, input logic [15:0] xp,
                      input logic [2:0] xf);
    @(negedge clk);
    {bus.if_valid, bus.if_err, bus.if_busy, bus.stall, bus.flush} = ctl;
    bus.if_instr = ins;
    bus.if_pc2   = pc;
    exp_q.push_back(obs_t'({xi, xp, xf}));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    obs_q.push_back(obs_t'({bus.FD_instr, bus.FD_pc2, bus.FD_valid, bus.FD_err, bus.fd_ready}));
  endtask

  task automatic test_reset();
    obs_t o;
    #2;
    o = {bus.FD_instr, bus.FD_pc2, bus.FD_valid, bus.FD_err, bus.fd_ready};
    n_cmp++;
    if (o !== obs_t'({16'h0800, 16'h0000, 3'b001})) begin
      n_bad++;
      $display("FAIL reset: instr=%h pc2=%h valid=%b err=%b ready=%b, want 0800 0000 0 0 1",
               o.instr, o.pc2, o.valid, o.err, o.ready);
    end else begin
      $display("   reset: instr=%h pc2=%h valid=%b", o.instr, o.pc2, o.valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    obs_t o, e;
    string t;
    step("stream0", 5'b10000, 16'h4A21, 16'h0002, 16'h4A21, 16'h0002, 3'b101);
    step("stream1", 5'b10000, 16'h5B02, 16'h0004, 16'h5B02, 16'h0004, 3'b101);
    step("stream_idle", 5'b00000, 16'h0000, 16'h0000, 16'h0800, 16'h0004, 3'b001);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: instr=%h pc2=%h v=%b e=%b r=%b, want instr=%h pc2=%h v=%b e=%b r=%b",
                 t, o.instr, o.pc2, o.valid, o.err, o.ready, e.instr, e.pc2, e.valid, e.err, e.ready);
      end else $display("   %s: instr=%h pc2=%h v=%b e=%b r=%b", t, o.instr, o.pc2, o.valid, o.err, o.ready);
    end
  endtask

  task automatic test_flush_over_stall();
    obs_t o, e;
    string t;
    step("fs_load",  5'b10000, 16'h4A21, 16'h0010, 16'h4A21, 16'h0010, 3'b101);
    step("fs_stall1", 5'b00010, 16'h0000, 16'h0000, 16'h4A21, 16'h0010, {2'b10, SKID});
    step("fs_flush2", 5'b10011, 16'h9999, 16'h0012, 16'h0800, 16'h0010, {2'b00, SKID});
    step("fs_stall3", 5'b00010, 16'h0000, 16'h0000, 16'h0800, 16'h0010, {2'b00, SKID});
    step("fs_idle",  5'b00000, 16'h0000, 16'h0000, 16'h0800, 16'h0010, 3'b001);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: instr=%h pc2=%h v=%b e=%b r=%b, want instr=%h pc2=%h v=%b e=%b r=%b",
                 t, o.instr, o.pc2, o.valid, o.err, o.ready, e.instr, e.pc2, e.valid, e.err, e.ready);
      end else $display("   %s: instr=%h pc2=%h v=%b e=%b r=%b", t, o.instr, o.pc2, o.valid, o.err, o.ready);
    end
  endtask

  task automatic test_drop();
    obs_t o, e;
    string t;
    step("drop_flush", 5'b00101, 16'h0000, 16'h0000, 16'h0800, 16'h0010, 3'b001);
    step("drop_stale", 5'b10000, 16'h6C10, 16'h0020, 16'h0800, 16'h0010, 3'b001);
    step("drop_next",  5'b10000, 16'h7D00, 16'h0022, 16'h7D00, 16'h0022, 3'b101);
    step("drop2_flush", 5'b00101, 16'h0000, 16'h0000, 16'h0800, 16'h0022, 3'b001);
    step("drop2_reflush", 5'b00011, 16'h0000, 16'h0000, 16'h0800, 16'h0022, 3'b001);
    step("drop2_stale", 5'b10010, 16'hAAAA, 16'h0024, 16'h0800, 16'h0022, {2'b00, SKID});
    step("drop2_next", 5'b10000, 16'hBBBB, 16'h0026, 16'hBBBB, 16'h0026, 3'b101);
    step("flush_with_valid", 5'b10101, 16'h1111, 16'h0028, 16'h0800, 16'h0026, 3'b001);
    step("after_flush_valid", 5'b10000, 16'h2222, 16'h002A, 16'h2222, 16'h002A, 3'b101);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: instr=%h pc2=%h v=%b e=%b r=%b, want instr=%h pc2=%h v=%b e=%b r=%b",
                 t, o.instr, o.pc2, o.valid, o.err, o.ready, e.instr, e.pc2, e.valid, e.err, e.ready);
      end else $display("   %s: instr=%h pc2=%h v=%b e=%b r=%b", t, o.instr, o.pc2, o.valid, o.err, o.ready);
    end
  endtask

  task automatic test_err();
    obs_t o, e;
    string t;
    step("err_load",  5'b11000, 16'h1234, 16'h0030, 16'h1234, 16'h0030, 3'b111);
    step("err_flush", 5'b00001, 16'h0000, 16'h0000, 16'h0800, 16'h0030, 3'b001);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: instr=%h pc2=%h v=%b e=%b r=%b, want instr=%h pc2=%h v=%b e=%b r=%b",
                 t, o.instr, o.pc2, o.valid, o.err, o.ready, e.instr, e.pc2, e.valid, e.err, e.ready);
      end else $display("   %s: instr=%h pc2=%h v=%b e=%b r=%b", t, o.instr, o.pc2, o.valid, o.err, o.ready);
    end
  endtask

`ifdef FD_SKID_EN
  task automatic test_skid();
    obs_t o, e;
    string t;
    step("skid_pre",    5'b10000, 16'h3000, 16'h0050, 16'h3000, 16'h0050, 3'b101);
    step("skid_fill",   5'b10010, 16'h4A21, 16'h0052, 16'h3000, 16'h0050, 3'b100);
    step("skid_drain",  5'b00000, 16'h0000, 16'h0000, 16'h4A21, 16'h0052, 3'b101);
    step("skid_fill2",  5'b10010, 16'h6666, 16'h0054, 16'h4A21, 16'h0052, 3'b100);
    step("skid_flush",  5'b00011, 16'h0000, 16'h0000, 16'h0800, 16'h0052, 3'b001);
    step("skid_empty",  5'b00000, 16'h0000, 16'h0000, 16'h0800, 16'h0052, 3'b001);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: instr=%h pc2=%h v=%b e=%b r=%b, want instr=%h pc2=%h v=%b e=%b r=%b",
                 t, o.instr, o.pc2, o.valid, o.err, o.ready, e.instr, e.pc2, e.valid, e.err, e.ready);
      end else $display("   %s: instr=%h pc2=%h v=%b e=%b r=%b", t, o.instr, o.pc2, o.valid, o.err, o.ready);
    end
  endtask
`endif

  task automatic test_reset_mid();
    obs_t o, e;
    string t;
    step("mid_load", 5'b10000, 16'h4A21, 16'h0040, 16'h4A21, 16'h0040, 3'b101);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: instr=%h pc2=%h v=%b e=%b r=%b, want instr=%h pc2=%h v=%b e=%b r=%b",
                 t, o.instr, o.pc2, o.valid, o.err, o.ready, e.instr, e.pc2, e.valid, e.err, e.ready);
      end else $display("   %s: instr=%h pc2=%h v=%b e=%b r=%b", t, o.instr, o.pc2, o.valid, o.err, o.ready);
    end
    // Assert reset between edges; the bubble must appear without a clock.
    #2;
    rst = 1'b1;
    #1;
    o = {bus.FD_instr, bus.FD_pc2, bus.FD_valid, bus.FD_err, bus.fd_ready};
    n_cmp++;
    if ({o.instr, o.pc2, o.valid, o.err} !== {16'h0800, 16'h0000, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: instr=%h pc2=%h valid=%b err=%b, want 0800 0000 0 0",
               o.instr, o.pc2, o.valid, o.err);
    end else begin
      $display("   reset_mid: instr=%h pc2=%h valid=%b", o.instr, o.pc2, o.valid);
    end
    @(negedge clk);
    {bus.if_valid, bus.if_err, bus.if_busy, bus.stall, bus.flush} = 5'b00000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish before 100000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.if_valid = 1'b0;
    bus.if_instr = 16'h0000;
    bus.if_pc2   = 16'h0000;
    bus.if_err   = 1'b0;
    bus.if_busy  = 1'b0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    test_reset();
    test_stream();
    test_flush_over_stall();
    test_drop();
    test_err();
`ifdef FD_SKID_EN
    test_skid();
`endif
    test_reset_mid();
    test_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
